// File: rtl/al_pkg.sv
// Shared definitions for the auto-load PROM reader: FSM encoding, PROM read
// opcode and frame layout.
package al_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SHIFT,
        ST_DESELECT,
        ST_WRITE
    } al_state_t;

    localparam logic [7:0]  AL_READ_OP    = 8'h03;
    localparam int unsigned AL_FRAME_LEN  = 32;
    localparam logic [15:0] AL_BLANK_WORD = 16'hFFFF;

    // Read frame: opcode, zero-padded word address, then 16 data slots.
    function automatic logic [AL_FRAME_LEN-1:0] al_read_frame(input logic [5:0] addr);
        return {AL_READ_OP, 2'b00, addr, 16'h0000};
    endfunction

endpackage

// File: rtl/al_prom_reader_if.sv
// Sequencer-side handshake and register-bank write bus of the PROM reader.
interface al_prom_reader_if;

    logic        AL_ENA;
    logic        EXECUTE;
    logic [5:0]  AL_CNT;
    logic        CLR_AL_DONE;
    logic        BUSY;
    logic        AL_DONE;
    logic [15:0] DATA;
    logic [5:0]  DATA_ADDR;
    logic        DATA_WE;

    modport master (
        output AL_ENA, EXECUTE, AL_CNT, CLR_AL_DONE,
        input  BUSY, AL_DONE, DATA, DATA_ADDR, DATA_WE
    );

    modport slave (
        input  AL_ENA, EXECUTE, AL_CNT, CLR_AL_DONE,
        output BUSY, AL_DONE, DATA, DATA_ADDR, DATA_WE
    );

endinterface

// File: rtl/prom_spi_shifter.sv
// Bit timing for the PROM serial link: SCK divider, 32-bit transmit shift
// register, bit counter and receive word capture.
module prom_spi_shifter
    import al_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    load,
    input  logic                    active,
    input  logic                    shifting,
    input  logic [AL_FRAME_LEN-1:0] frame,
    input  logic                    so,
    output logic                    si,
    output logic [15:0]             rx_word,
    output logic                    sck_rise,
    output logic                    sck_fall,
    output logic                    frame_done
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [4:0] BIT_LAST = 5'(AL_FRAME_LEN - 1);

    logic [3:0]              div_cnt;
    logic                    phase;
    logic [4:0]              bit_cnt;
    logic [AL_FRAME_LEN-1:0] sr;
    logic                    half_end;

    // Enables describe the SCK transition taking effect on the coming edge.
    always_comb begin
        half_end   = shifting && (div_cnt == DIV_LAST);
        sck_rise   = half_end && !phase;
        sck_fall   = half_end && phase && (bit_cnt != BIT_LAST);
        frame_done = half_end && phase && (bit_cnt == BIT_LAST);
    end

    always_ff @(posedge CLK) begin
        if (RST || !shifting) begin
            div_cnt <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
        end else if (half_end) begin
            div_cnt <= '0;
            phase   <= !phase;
            if (phase) begin
                bit_cnt <= bit_cnt + 5'd1;
            end
        end else begin
            div_cnt <= div_cnt + 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sr <= '0;
        end else if (load) begin
            sr <= frame;
        end else if (!active) begin
            sr <= '0;
        end else if (sck_fall) begin
            sr <= {sr[AL_FRAME_LEN-2:0], 1'b0};
        end
    end

    // Every bit is captured; only the last 16 (the data word) survive.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_word <= '0;
        end else if (sck_rise) begin
            rx_word <= {rx_word[14:0], so};
        end
    end

    assign si = sr[AL_FRAME_LEN-1];

endmodule

// File: rtl/al_prom_reader.sv
// Auto-load responder: reads one 16-bit word from the serial PROM per
// EXECUTE, writes it to the register bank and maintains the AL_DONE flag.
module al_prom_reader
    import al_pkg::*;
#(
    parameter logic [5:0]  MAX_ADDR   = 6'd33,
    parameter int unsigned CLK_DIV    = 4,
    parameter logic [15:0] BLANK_WORD = AL_BLANK_WORD
) (
    input  logic            CLK,
    input  logic            RST,
    al_prom_reader_if.slave bus,
    output logic            PROM_CS_B,
    output logic            PROM_SCK,
    output logic            PROM_SI,
    input  logic            PROM_SO
);

    al_state_t   state, state_nxt;
    logic [5:0]  addr;
    logic        start;
    logic        sck_rise, sck_fall, frame_done;
    logic [15:0] rx_word;
    logic        done_hit;

    prom_spi_shifter #(
        .CLK_DIV(CLK_DIV)
    ) u_shifter (
        .CLK       (CLK),
        .RST       (RST),
        .load      (start),
        .active    (bus.AL_ENA && (state == ST_SELECT || state == ST_SHIFT)),
        .shifting  (bus.AL_ENA && (state == ST_SHIFT)),
        .frame     (al_read_frame(bus.AL_CNT)),
        .so        (PROM_SO),
        .si        (PROM_SI),
        .rx_word   (rx_word),
        .sck_rise  (sck_rise),
        .sck_fall  (sck_fall),
        .frame_done(frame_done)
    );

    always_comb begin
        start     = (state == ST_IDLE) && bus.EXECUTE && bus.AL_ENA;
        state_nxt = state;
        if (state != ST_IDLE && !bus.AL_ENA) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     if (start) state_nxt = ST_SELECT;
                ST_SELECT:   state_nxt = ST_SHIFT;
                ST_SHIFT:    if (frame_done) state_nxt = ST_DESELECT;
                ST_DESELECT: state_nxt = ST_WRITE;
                ST_WRITE:    state_nxt = ST_IDLE;
                default:     state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DATA/DATA_ADDR are already updated during Write, so they drive the check.
    always_comb begin
        done_hit = (bus.DATA_ADDR == MAX_ADDR) ||
                   ((bus.DATA_ADDR == 6'd0) && (bus.DATA == BLANK_WORD));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            addr          <= '0;
            bus.BUSY      <= 1'b0;
            bus.AL_DONE   <= 1'b0;
            bus.DATA      <= '0;
            bus.DATA_ADDR <= '0;
            bus.DATA_WE   <= 1'b0;
            PROM_CS_B     <= 1'b1;
            PROM_SCK      <= 1'b0;
        end else begin
            if (start) begin
                addr <= bus.AL_CNT;
            end
            bus.BUSY    <= (state_nxt != ST_IDLE);
            bus.DATA_WE <= (state_nxt == ST_WRITE);
            PROM_CS_B   <= !(state_nxt == ST_SELECT || state_nxt == ST_SHIFT);
            if (state_nxt != ST_SHIFT) begin
                PROM_SCK <= 1'b0;
            end else if (sck_rise) begin
                PROM_SCK <= 1'b1;
            end else if (sck_fall) begin
                PROM_SCK <= 1'b0;
            end
            if (state == ST_DESELECT && state_nxt == ST_WRITE) begin
                bus.DATA      <= rx_word;
                bus.DATA_ADDR <= addr;
            end
            if (bus.CLR_AL_DONE) begin
                bus.AL_DONE <= 1'b0;
            end else if (state == ST_WRITE && done_hit) begin
                bus.AL_DONE <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_al_prom_reader.sv
// Directed bench for al_prom_reader with a behavioural serial PROM model.
module tb_al_prom_reader;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RST;
    al_prom_reader_if b4();
    al_prom_reader_if b1();
    al_prom_reader_if b15();

    logic cs4, sck4, si4;
    logic so4 = 1'b0;
    logic cs1, sck1, si1, cs15, sck15, si15;

    al_prom_reader #(.MAX_ADDR(6'd33), .CLK_DIV(4), .BLANK_WORD(16'hFFFF)) dut (
        .CLK(CLK), .RST(RST), .bus(b4),
        .PROM_CS_B(cs4), .PROM_SCK(sck4), .PROM_SI(si4), .PROM_SO(so4));
    al_prom_reader #(.CLK_DIV(1)) dut_d1 (
        .CLK(CLK), .RST(RST), .bus(b1),
        .PROM_CS_B(cs1), .PROM_SCK(sck1), .PROM_SI(si1), .PROM_SO(1'b0));
    al_prom_reader #(.CLK_DIV(15)) dut_d15 (
        .CLK(CLK), .RST(RST), .bus(b15),
        .PROM_CS_B(cs15), .PROM_SCK(sck15), .PROM_SI(si15), .PROM_SO(1'b0));

    int tests = 0;
    int fails = 0;

    // Monitors sample on the falling edge; stimulus runs 1 unit later.
    int cyc = 0;
    int busy4 = 0, busy4_last = 0, we_cnt = 0, we_pos = 0;
    int busy1 = 0, busy1_last = 0, busy15 = 0, busy15_last = 0;
    int rise1_cyc = 0, per1 = 0, rise15_cyc = 0, per15 = 0;
    logic prev_sck1 = 1'b0, prev_sck15 = 1'b0;

    always @(negedge CLK) begin
        cyc++;
        if (b4.BUSY) busy4++;
        else begin
            if (busy4 != 0) busy4_last = busy4;
            busy4 = 0;
        end
        if (b4.DATA_WE) begin
            we_cnt++;
            we_pos = busy4;
        end
        if (b1.BUSY) busy1++;
        else begin
            if (busy1 != 0) busy1_last = busy1;
            busy1 = 0;
        end
        if (b15.BUSY) busy15++;
        else begin
            if (busy15 != 0) busy15_last = busy15;
            busy15 = 0;
        end
        if (sck1 && !prev_sck1) begin
            per1 = cyc - rise1_cyc;
            rise1_cyc = cyc;
        end
        if (sck15 && !prev_sck15) begin
            per15 = cyc - rise15_cyc;
            rise15_cyc = cyc;
        end
        prev_sck1 = sck1;
        prev_sck15 = sck15;
    end

    // PROM model for the CLK_DIV=4 instance.
    logic [15:0] mem [64];
    int          m_cnt = 0, cs_rise = 0;
    logic [15:0] m_cmd = '0, cmd_seen = '0, m_word = '0;
    logic [3:0]  idx;
    logic        prev_cs4 = 1'b1, prev_sck4 = 1'b0;

    always @(negedge CLK) begin
        if (cs4) begin
            if (!prev_cs4) cs_rise++;
            m_cnt = 0;
        end else begin
            if (sck4 && !prev_sck4) begin
                if (m_cnt < 16) m_cmd = {m_cmd[14:0], si4};
                m_cnt++;
                if (m_cnt == 16) begin
                    cmd_seen = m_cmd;
                    m_word = mem[m_cmd[5:0]];
                end
            end else if (!sck4 && prev_sck4 && m_cnt >= 16 && m_cnt < 32) begin
                idx = 4'(31 - m_cnt);
                so4 = m_word[idx];
            end
        end
        prev_cs4 = cs4;
        prev_sck4 = sck4;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 1200 && b4.BUSY; i++) step();
        chk("busy_timeout", b4.BUSY, 0);
    endtask

    task automatic do_read(input logic [5:0] a);
        b4.AL_CNT = a;
        b4.EXECUTE = 1'b1;
        step();
        b4.EXECUTE = 1'b0;
        chk("busy_after_exec", b4.BUSY, 1);
        wait_idle();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int we_before, cs_before;
    logic [15:0] exp_w;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        mem[5] = 16'h1234;
        mem[0] = 16'hFFFF;
        mem[4] = 16'h5A5A;
        RST = 1'b1;
        b4.AL_ENA = 1'b1;  b4.EXECUTE = 1'b0;  b4.AL_CNT = '0;  b4.CLR_AL_DONE = 1'b0;
        b1.AL_ENA = 1'b1;  b1.EXECUTE = 1'b0;  b1.AL_CNT = '0;  b1.CLR_AL_DONE = 1'b0;
        b15.AL_ENA = 1'b1; b15.EXECUTE = 1'b0; b15.AL_CNT = '0; b15.CLR_AL_DONE = 1'b0;
        repeat (3) step();
        RST = 1'b0;
        step();

        chk("rst_ctrl", {b4.BUSY, b4.AL_DONE, b4.DATA_WE, cs4, sck4, si4}, 6'b000100);
        chk("rst_data", {b4.DATA_ADDR, b4.DATA}, 22'h0);

        // single read
        do_read(6'd5);
        chk("rd5_cmd", cmd_seen, 16'h0305);
        chk("rd5_we_cnt", we_cnt, 1);
        chk("rd5_data", b4.DATA, 16'h1234);
        chk("rd5_addr", b4.DATA_ADDR, 5);
        chk("rd5_busy_w", busy4_last, 259);
        chk("rd5_we_pos", we_pos, 259);
        chk("rd5_done", b4.AL_DONE, 0);
        chk("rd5_idle_pins", {cs4, sck4}, 2'b10);

        // blank PROM
        do_read(6'd0);
        chk("blank_cmd", cmd_seen, 16'h0300);
        chk("blank_done", b4.AL_DONE, 1);

        // reset mid-shift
        cs_before = cs_rise;
        b4.AL_CNT = 6'd4;
        b4.EXECUTE = 1'b1;
        step();
        b4.EXECUTE = 1'b0;
        repeat (50) step();
        chk("pre_rst_cs", cs4, 0);
        RST = 1'b1;
        step();
        chk("midrst_ctrl", {b4.BUSY, b4.AL_DONE, b4.DATA_WE, cs4, sck4, si4}, 6'b000100);
        chk("midrst_data", {b4.DATA_ADDR, b4.DATA}, 22'h0);
        chk("midrst_cs_rise", cs_rise, cs_before + 1);
        RST = 1'b0;
        step();

        // address 0 with non-blank data
        mem[0] = 16'h0000;
        do_read(6'd0);
        chk("zero_done", b4.AL_DONE, 0);
        mem[0] = 16'hFFFF;
        do_read(6'd0);
        chk("blank2_done", b4.AL_DONE, 1);
        b4.CLR_AL_DONE = 1'b1;
        step();
        b4.CLR_AL_DONE = 1'b0;
        chk("clr_done", b4.AL_DONE, 0);

        // full table walk
        for (int i = 0; i < 64; i++) mem[i] = 16'hA000 | 16'(i);
        mem[0] = 16'h1357;
        we_before = we_cnt;
        for (int i = 0; i <= 33; i++) begin
            do_read(6'(i));
            exp_w = (i == 0) ? 16'h1357 : (16'hA000 | 16'(i));
            chk("walk_data", b4.DATA, exp_w);
            chk("walk_done", b4.AL_DONE, (i == 33) ? 1 : 0);
        end
        chk("walk_we_cnt", we_cnt - we_before, 34);

        // clear coinciding with set
        b4.AL_CNT = 6'd33;
        b4.EXECUTE = 1'b1;
        step();
        b4.EXECUTE = 1'b0;
        for (int i = 0; i < 400 && !b4.DATA_WE; i++) step();
        chk("coinc_we", b4.DATA_WE, 1);
        b4.CLR_AL_DONE = 1'b1;
        step();
        b4.CLR_AL_DONE = 1'b0;
        chk("coinc_busy", b4.BUSY, 0);
        chk("coinc_done", b4.AL_DONE, 0);

        // EXECUTE while busy is dropped
        we_before = we_cnt;
        b4.AL_CNT = 6'd7;
        b4.EXECUTE = 1'b1;
        step();
        b4.EXECUTE = 1'b0;
        repeat (10) step();
        b4.AL_CNT = 6'd9;
        b4.EXECUTE = 1'b1;
        step();
        b4.EXECUTE = 1'b0;
        wait_idle();
        chk("busyexec_addr", b4.DATA_ADDR, 7);
        chk("busyexec_busy_w", busy4_last, 259);
        repeat (5) step();
        chk("busyexec_noq", b4.BUSY, 0);
        chk("busyexec_we", we_cnt - we_before, 1);

        // EXECUTE with AL_ENA low
        b4.AL_ENA = 1'b0;
        b4.AL_CNT = 6'd2;
        b4.EXECUTE = 1'b1;
        step();
        b4.EXECUTE = 1'b0;
        chk("noena_busy", {b4.BUSY, cs4}, 2'b01);
        b4.AL_ENA = 1'b1;
        step();

        // AL_ENA dropped at bit 20
        we_before = we_cnt;
        b4.AL_CNT = 6'd3;
        b4.EXECUTE = 1'b1;
        step();
        b4.EXECUTE = 1'b0;
        for (int i = 0; i < 400 && m_cnt < 20; i++) step();
        chk("abort_reach20", m_cnt, 20);
        b4.AL_ENA = 1'b0;
        step();
        chk("abort_pins", {b4.BUSY, cs4, sck4}, 3'b010);
        b4.AL_ENA = 1'b1;
        repeat (5) step();
        chk("abort_no_we", we_cnt - we_before, 0);
        chk("abort_data", {b4.DATA_ADDR, b4.DATA}, {6'd7, 16'hA007});

        // divider extremes
        b1.EXECUTE = 1'b1;
        b15.EXECUTE = 1'b1;
        step();
        b1.EXECUTE = 1'b0;
        b15.EXECUTE = 1'b0;
        chk("div_busy_on", {b1.BUSY, b15.BUSY}, 2'b11);
        for (int i = 0; i < 1100 && (b1.BUSY || b15.BUSY); i++) step();
        chk("div1_busy_w", busy1_last, 67);
        chk("div15_busy_w", busy15_last, 963);
        chk("div1_period", per1, 2);
        chk("div15_period", per15, 30);
        chk("div_idle_pins", {cs1, sck1, si1, cs15, sck15, si15}, 6'b100100);
        chk("div_results", {b1.DATA, b15.DATA, b1.AL_DONE, b15.AL_DONE}, 34'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
